// File: rtl/fft_state3_if.sv
// rtl/fft_state3_if.sv - sample-pair bus into and out of the radix-2 SDF stage 3 butterfly
interface fft_state3_if #(
    parameter int WIDTH = 9
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_up_re;
    logic signed [WIDTH-1:0] in_up_im;
    logic signed [WIDTH-1:0] in_l_re;
    logic signed [WIDTH-1:0] in_l_im;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_up_re;
    logic signed [WIDTH-1:0] out_up_im;
    logic signed [WIDTH-1:0] out_l_re;
    logic signed [WIDTH-1:0] out_l_im;

    modport master (
        output in_valid, in_up_re, in_up_im, in_l_re, in_l_im,
        input  out_valid, out_up_re, out_up_im, out_l_re, out_l_im
    );

    modport slave (
        input  in_valid, in_up_re, in_up_im, in_l_re, in_l_im,
        output out_valid, out_up_re, out_up_im, out_l_re, out_l_im
    );
endinterface

// File: rtl/fft_state3.sv
// rtl/fft_state3.sv - FFT stage 3: 4-deep commutator/delay lines, butterfly, W8 twiddle multiply
module fft_state3 #(
    parameter int WIDTH = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    fft_state3_if.slave  bus
);
    localparam int PW = WIDTH + 11;

    logic [2:0] cnt;
    logic [3:0] fill;

    logic signed [WIDTH-1:0] dly_l_re [4];
    logic signed [WIDTH-1:0] dly_l_im [4];
    logic signed [WIDTH-1:0] dly_u_re [4];
    logic signed [WIDTH-1:0] dly_u_im [4];

    logic signed [WIDTH-1:0] com_up_re, com_up_im;
    logic signed [WIDTH-1:0] com_l_re, com_l_im;
    logic signed [WIDTH:0]   sum_re, sum_im, diff_re, diff_im;
    logic signed [8:0]       w_re, w_im;
    logic signed [PW-1:0]    prod_re, prod_im;

    always_comb begin
        // cnt[2] swaps which path is delayed and which meets the delayed sample
        if (cnt[2]) begin
            com_up_re = dly_l_re[3];
            com_up_im = dly_l_im[3];
            com_l_re  = bus.in_up_re;
            com_l_im  = bus.in_up_im;
        end else begin
            com_up_re = bus.in_up_re;
            com_up_im = bus.in_up_im;
            com_l_re  = dly_l_re[3];
            com_l_im  = dly_l_im[3];
        end

        sum_re  = $signed({dly_u_re[3][WIDTH-1], dly_u_re[3]}) + $signed({com_l_re[WIDTH-1], com_l_re});
        sum_im  = $signed({dly_u_im[3][WIDTH-1], dly_u_im[3]}) + $signed({com_l_im[WIDTH-1], com_l_im});
        diff_re = $signed({dly_u_re[3][WIDTH-1], dly_u_re[3]}) - $signed({com_l_re[WIDTH-1], com_l_re});
        diff_im = $signed({dly_u_im[3][WIDTH-1], dly_u_im[3]}) - $signed({com_l_im[WIDTH-1], com_l_im});

        // Q2.7 twiddles for W8^k, k = 0..3
        w_re = 9'sd128;
        w_im = 9'sd0;
        case (cnt[1:0])
            2'd0: begin w_re = 9'sd128;  w_im = 9'sd0;    end
            2'd1: begin w_re = 9'sd91;   w_im = -9'sd91;  end
            2'd2: begin w_re = 9'sd0;    w_im = -9'sd128; end
            default: begin w_re = -9'sd91; w_im = -9'sd91; end
        endcase

        prod_re = PW'(diff_re) * PW'(w_re) - PW'(diff_im) * PW'(w_im);
        prod_im = PW'(diff_re) * PW'(w_im) + PW'(diff_im) * PW'(w_re);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt           <= 3'd0;
            fill          <= 4'd0;
            bus.out_valid <= 1'b0;
            bus.out_up_re <= '0;
            bus.out_up_im <= '0;
            bus.out_l_re  <= '0;
            bus.out_l_im  <= '0;
            for (int k = 0; k < 4; k++) begin
                dly_l_re[k] <= '0;
                dly_l_im[k] <= '0;
                dly_u_re[k] <= '0;
                dly_u_im[k] <= '0;
            end
        end else if (bus.in_valid) begin
            cnt <= cnt + 3'd1;
            if (fill != 4'd8) begin
                fill <= fill + 4'd1;
            end
            bus.out_valid <= (fill >= 4'd7);
            for (int k = 3; k > 0; k--) begin
                dly_l_re[k] <= dly_l_re[k-1];
                dly_l_im[k] <= dly_l_im[k-1];
                dly_u_re[k] <= dly_u_re[k-1];
                dly_u_im[k] <= dly_u_im[k-1];
            end
            dly_l_re[0] <= bus.in_l_re;
            dly_l_im[0] <= bus.in_l_im;
            dly_u_re[0] <= com_up_re;
            dly_u_im[0] <= com_up_im;
            // slicing the wide product is the floor shift by 7 plus wrap to WIDTH bits
            bus.out_up_re <= sum_re[WIDTH-1:0];
            bus.out_up_im <= sum_im[WIDTH-1:0];
            bus.out_l_re  <= prod_re[WIDTH+6:7];
            bus.out_l_im  <= prod_im[WIDTH+6:7];
        end else begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/fft_state3.md
FFT_STATE3 -- requirements
Module: fft_state3

Interface
REQ-001 Parameter: WIDTH, default 9, signed two's-complement width of every data input and output.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-high reset (high = reset, despite the name).
REQ-004 in_valid  input  1  high = one sample pair accepted this cycle; low = pipeline holds.
REQ-005 in_up_re, in_up_im  input  WIDTH each  upper-path sample from the preceding stage.
REQ-006 in_l_re, in_l_im  input  WIDTH each  lower-path sample from the preceding stage.
REQ-007 out_valid  output  1  high = output pair below carries a valid result.
REQ-008 out_up_re, out_up_im  output  WIDTH each  butterfly sum, registered.
REQ-009 out_l_re, out_l_im  output  WIDTH each  twiddled butterfly difference, registered.

Function
REQ-010 Phase counter cnt[2:0] SHALL increment by 1, wrapping 7->0, on every cycle with in_valid=1, and SHALL hold otherwise.
REQ-011 Lower delay line SHALL be a 4-deep shift register on in_l, advancing only when in_valid=1; its tap is dlyL (input from 4 accepted samples earlier).
REQ-012 Commutator sel = cnt[2]: sel=0 gives com_up=in_up and com_l=dlyL; sel=1 gives com_up=dlyL and com_l=in_up.
REQ-013 Upper delay line SHALL be a 4-deep shift register on com_up, advancing only when in_valid=1; its tap is operand A; com_l is operand B.
REQ-014 Butterfly SHALL compute sum=A+B and diff=A-B at WIDTH+1 bits with sign extension, without saturation.
REQ-015 Twiddle ROM SHALL be indexed by k=cnt[1:0] and hold 9-bit Q2.7 values (re,im): k0 (128,0), k1 (91,-91), k2 (0,-128), k3 (-91,-91).
REQ-016 Complex multiply SHALL give re=diff_re*w_re-diff_im*w_im and im=diff_re*w_im+diff_im*w_re, at full precision (WIDTH+11 bits).
REQ-017 out_l SHALL be the product arithmetic-shifted right by 7 (floor, no rounding) and truncated to bits [WIDTH+6:7], with two's-complement wrap on overflow.
REQ-018 out_up SHALL be sum[WIDTH-1:0], with wrap on overflow.
REQ-019 Output registers SHALL load one cycle after each cycle with in_valid=1; latency from accepted sample to registered output is 1 clk.
REQ-020 Fill counter SHALL count accepted samples up to 8 and saturate; out_valid SHALL be 1 the cycle after an accepted sample only once that sample has brought the count to 8, and 0 otherwise.
REQ-021 With in_valid=0, out_valid SHALL drop to 0 the next cycle and out_* SHALL hold their last values.
REQ-022 With in_valid=1 in consecutive cycles, throughput SHALL be one pair per clk with no bubbles.

Reset
REQ-023 Reset assertion SHALL asynchronously clear cnt, the fill counter, both delay lines, all out_* to 0 and out_valid to 0.
REQ-024 Reset mid-stream SHALL discard all in-flight data; after release the block SHALL behave as from power-up and need 8 new accepted samples before out_valid=1.
REQ-025 No output SHALL depend on pre-reset state after release.

Verification
REQ-026 Reset then 16 consecutive valid cycles with in_up=(10,0) and in_l=(4,0) -> out_valid low for the first 7 output cycles; once valid, out_up alternates in blocks of 4 between (8,0) for cnt 0-3 and (20,0) for cnt 4-7; out_l is (0,0) throughout.
REQ-027 Directed k=2 case: A=(10,0), B=(4,0) at cnt=2 -> out_up=(14,0), out_l=(0,-6).
REQ-028 Directed k=3 rounding case: diff=(1,0) -> out_l=(-1,-1), confirming floor not round.
REQ-029 Valid pattern 1,0,0,1,... -> cnt and both delay lines advance only on valid cycles; results equal the back-to-back run.
REQ-030 Assert reset after 5 valid samples, release, then send 8 more -> out_valid first high after the 8th post-reset sample; all outputs 0 during reset.
REQ-031 Overflow case: in_up=(255,0) and in_l=(255,0) with WIDTH=9 -> out_up_re=510 wrapped to -2, with no X values.
